io_bus_arbiter: RTL and testbench
=================================

# io_bus_arbiter

Round-robin arbiter that shares the single CPU-side slave port of the I/O bridge between up to four bus masters (CPU cores, DMA, debug). It grants one master at a time for the full duration of its bus cycle, tags the cycle with the master index on the core-ID lines, and returns acknowledge and read data only to the granted master. A per-cycle watchdog terminates unanswered cycles with a bus error so a missing I/O device cannot hang a master.

## Interface
- NMST, 4: number of masters (2..4)
- TMO, 255: watchdog limit in clocks, 8-bit counter
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- m_cyc_i  in  NMST  per-master cycle
- m_stb_i  in  NMST  per-master strobe
- m_we_i  in  NMST  per-master write enable
- m_sel_i  in  4*NMST  byte selects, master k at [4k+3:4k]
- m_adr_i  in  32*NMST  addresses, master k at [32k+31:32k]
- m_dat_i  in  32*NMST  write data, same packing
- m_ack_o  out  NMST  per-master acknowledge, registered
- m_err_o  out  NMST  per-master bus error, registered
- m_dat_o  out  32  read data, valid to granted master with its ack
- s_core_o  out  6  core tag, {4'b0, grant index}
- s_cyc_o, s_stb_o, s_we_o  out  1 each  to bridge slave port
- s_sel_o  out  4;  s_adr_o  out  32;  s_dat_o  out  32
- s_ack_i  in  1;  s_dat_i  in  32;  s_core_i  in  6

## Operation
- States: IDLE, BUSY, HOLD, ERR. Grant register gnt (2 bits), pointer last (2 bits).
- IDLE: req = m_cyc_i & m_stb_i. If any, choose first set bit searching last+1, last+2, … modulo NMST; gnt <= choice, last <= choice, latch that master's we/sel/adr/dat onto s_* outputs, s_cyc_o = s_stb_o = 1, clear watchdog, go BUSY.
- BUSY: watchdog increments each clock.
  - s_ack_i: s_cyc_o/s_stb_o/s_we_o <= 0, m_dat_o <= s_dat_i, m_ack_o[gnt] <= 1, go HOLD.
  - else m_cyc_i[gnt] low (abort): drop s_* strobes, go IDLE, no ack.
  - else watchdog == TMO: drop s_* strobes, m_err_o[gnt] <= 1, go ERR.
  - Priority: ack > abort > timeout when simultaneous.
- HOLD / ERR: hold ack (err) and m_dat_o until m_stb_i[gnt] low, then clear m_ack_o/m_err_o, m_dat_o <= 0, go IDLE.
- s_core_i is ignored except that a mismatch with s_core_o at ack is still acked (tag is informational).
- Non-granted masters see ack/err 0 throughout; their requests wait.
- Reset: all outputs 0, s_adr_o 32'hFFFFFFFF, state IDLE, gnt 0, last NMST-1 (master 0 wins first), watchdog 0.

## Timing
- Request sampled in IDLE to s_cyc_o high: 1 clock.
- s_ack_i to m_ack_o: 1 clock; s_strobes fall on the same edge.
- Minimum turnaround: after m_stb_i falls, state IDLE next clock; a new grant issues the clock after that (2 idle clocks between back-to-back grants, matching the bridge's own WAIT_NACK recovery).
- Timeout: m_err_o rises TMO+1 clocks after s_cyc_o rises.
- Reset deassertion mid-cycle: all strobes already cleared asynchronously; no residual ack.
- s_* outputs change only on IDLE->BUSY and BUSY exits; stable while BUSY.

## Test plan
- Single master 1 reads 0xFD00_0010; slave acks 3 clocks later with 0x1234_5678 -> m_ack_o=4'b0010, m_dat_o=0x12345678, s_core_o=6'd1, ack clears clock after m_stb_i[1] drops.
- Masters 0..3 request continuously -> grant order 0,1,2,3,0 with last updating; no master granted twice consecutively while others wait.
- Master 2 write, slave never acks, TMO=255 -> m_err_o[2] rises 256 clocks after s_cyc_o, s_cyc_o low, returns IDLE after stb drop.
- Master 0 drops m_cyc_i in BUSY before ack -> s_cyc_o low next clock, no m_ack_o, master 1 pending then granted.
- s_ack_i and watchdog expiry on same clock -> ack delivered, m_err_o stays 0.
- rst_ni asserted during BUSY -> all outputs 0 immediately, s_adr_o=0xFFFFFFFF; after release master 0 wins first contest.

Source files
------------

// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter sharing the bridge slave port among NMST bus masters.
// One master is granted per bus cycle; a watchdog turns unanswered cycles into bus errors.
module io_bus_arbiter #(
  parameter int NMST = 4,
  parameter int TMO  = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NMST-1:0]      m_cyc_i,
  input  logic [NMST-1:0]      m_stb_i,
  input  logic [NMST-1:0]      m_we_i,
  input  logic [4*NMST-1:0]    m_sel_i,
  input  logic [32*NMST-1:0]   m_adr_i,
  input  logic [32*NMST-1:0]   m_dat_i,
  output logic [NMST-1:0]      m_ack_o,
  output logic [NMST-1:0]      m_err_o,
  output logic [31:0]          m_dat_o,
  output logic [5:0]           s_core_o,
  output logic                 s_cyc_o,
  output logic                 s_stb_o,
  output logic                 s_we_o,
  output logic [3:0]           s_sel_o,
  output logic [31:0]          s_adr_o,
  output logic [31:0]          s_dat_o,
  input  logic                 s_ack_i,
  input  logic [31:0]          s_dat_i,
  input  logic [5:0]           s_core_i
);

  // state | meaning
  // IDLE  | no cycle on the slave port, arbitrating pending requests
  // BUSY  | cycle of master gnt on the slave port, watchdog running
  // HOLD  | ack and read data held until the master drops its strobe
  // ERR   | bus error held until the master drops its strobe
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;
  localparam logic [7:0] TMO_C  = 8'(TMO);

  logic [1:0]       state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       last_q, last_d;
  logic [7:0]       wdog_q, wdog_d;
  logic [NMST-1:0]  ack_q, ack_d;
  logic [NMST-1:0]  err_q, err_d;
  logic [31:0]      mdat_q, mdat_d;
  logic             cyc_q, cyc_d;
  logic             we_q, we_d;
  logic [3:0]       sel_q, sel_d;
  logic [31:0]      adr_q, adr_d;
  logic [31:0]      sdat_q, sdat_d;

  logic [NMST-1:0]  req;
  logic [NMST-1:0]  gnt_oh;
  logic             found;
  logic [1:0]       pick;
  logic             we_pick;
  logic [3:0]       sel_pick;
  logic [31:0]      adr_pick;
  logic [31:0]      dat_pick;
  logic             gnt_cyc;
  logic             gnt_stb;
  logic             unused_core;

  // The returned core tag is informational only.
  assign unused_core = ^s_core_i;

  assign req = m_cyc_i & m_stb_i;

  // Search last+1, last+2, ... so the previous winner has lowest priority.
  always_comb begin
    found = 1'b0;
    pick  = 2'd0;
    for (int i = 1; i <= NMST; i++) begin
      for (int k = 0; k < NMST; k++) begin
        if (!found && req[k] && (k == (int'(last_q) + i) % NMST)) begin
          found = 1'b1;
          pick  = 2'(k);
        end
      end
    end
  end

  always_comb begin
    we_pick  = 1'b0;
    sel_pick = '0;
    adr_pick = '0;
    dat_pick = '0;
    gnt_oh   = '0;
    for (int k = 0; k < NMST; k++) begin
      if (pick == 2'(k)) begin
        we_pick  = m_we_i[k];
        sel_pick = m_sel_i[4*k +: 4];
        adr_pick = m_adr_i[32*k +: 32];
        dat_pick = m_dat_i[32*k +: 32];
      end
      gnt_oh[k] = (gnt_q == 2'(k));
    end
  end

  assign gnt_cyc = |(m_cyc_i & gnt_oh);
  assign gnt_stb = |(m_stb_i & gnt_oh);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    wdog_d  = wdog_q;
    ack_d   = ack_q;
    err_d   = err_q;
    mdat_d  = mdat_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    sel_d   = sel_q;
    adr_d   = adr_q;
    sdat_d  = sdat_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          gnt_d   = pick;
          last_d  = pick;
          we_d    = we_pick;
          sel_d   = sel_pick;
          adr_d   = adr_pick;
          sdat_d  = dat_pick;
          cyc_d   = 1'b1;
          wdog_d  = 8'd0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        wdog_d = wdog_q + 8'd1;
        // Ack wins over abort, abort wins over timeout.
        if (s_ack_i) begin
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          mdat_d  = s_dat_i;
          ack_d   = gnt_oh;
          state_d = S_HOLD;
        end else if (!gnt_cyc) begin
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          state_d = S_IDLE;
        end else if (wdog_q == TMO_C) begin
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          err_d   = gnt_oh;
          state_d = S_ERR;
        end
      end
      S_HOLD, S_ERR: begin
        if (!gnt_stb) begin
          ack_d   = '0;
          err_d   = '0;
          mdat_d  = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      gnt_q   <= 2'd0;
      last_q  <= 2'(NMST - 1);
      wdog_q  <= 8'd0;
      ack_q   <= '0;
      err_q   <= '0;
      mdat_q  <= '0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      adr_q   <= 32'hFFFF_FFFF;
      sdat_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      mdat_q  <= mdat_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      sdat_q  <= sdat_d;
    end
  end

  assign m_ack_o  = ack_q;
  assign m_err_o  = err_q;
  assign m_dat_o  = mdat_q;
  assign s_core_o = {4'b0000, gnt_q};
  assign s_cyc_o  = cyc_q;
  assign s_stb_o  = cyc_q;
  assign s_we_o   = we_q;
  assign s_sel_o  = sel_q;
  assign s_adr_o  = adr_q;
  assign s_dat_o  = sdat_q;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Bench for io_bus_arbiter: directed scenarios plus randomized traffic
// checked against a round-robin reference model.
module tb_io_bus_arbiter;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [3:0]    m_cyc_i, m_stb_i, m_we_i;
  logic [15:0]   m_sel_i;
  logic [127:0]  m_adr_i, m_dat_i;
  logic [3:0]    m_ack_o, m_err_o;
  logic [31:0]   m_dat_o;
  logic [5:0]    s_core_o;
  logic          s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]    s_sel_o;
  logic [31:0]   s_adr_o, s_dat_o;
  logic          s_ack_i;
  logic [31:0]   s_dat_i;
  logic [5:0]    s_core_i;

  logic [3:0]    cyc_v, stb_v, f_we;
  logic [3:0]    f_sel [4];
  logic [31:0]   f_adr [4];
  logic [31:0]   f_dat [4];

  int checks = 0;
  int failures = 0;
  int last_m = 3;
  int g;

  io_bus_arbiter #(.NMST(4), .TMO(255)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_sel_i(m_sel_i), .m_adr_i(m_adr_i), .m_dat_i(m_dat_i),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_dat_o(m_dat_o),
    .s_core_o(s_core_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_sel_o(s_sel_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
    .s_ack_i(s_ack_i), .s_dat_i(s_dat_i), .s_core_i(s_core_i)
  );

  always #5 clk_i = ~clk_i;

  always_comb begin
    m_cyc_i = cyc_v;
    m_stb_i = stb_v;
    m_we_i  = f_we;
    for (int k = 0; k < 4; k++) begin
      m_sel_i[4*k +: 4]   = f_sel[k];
      m_adr_i[32*k +: 32] = f_adr[k];
      m_dat_i[32*k +: 32] = f_dat[k];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: first requester after the previous winner, modulo 4.
  function automatic int model_pick(input logic [3:0] r, input int last);
    for (int d = 1; d <= 4; d++)
      if (r[(last + d) % 4]) return (last + d) % 4;
    return -1;
  endfunction

  task automatic raise(input int k);
    f_adr[k] = $urandom;
    f_dat[k] = $urandom;
    f_sel[k] = 4'($urandom);
    f_we[k]  = 1'($urandom);
    cyc_v[k] = 1'b1;
    stb_v[k] = 1'b1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ack"},  32'(m_ack_o), 32'h0);
    chk({tag, "_err"},  32'(m_err_o), 32'h0);
    chk({tag, "_mdat"}, m_dat_o, 32'h0);
    chk({tag, "_cyc"},  32'(s_cyc_o), 32'h0);
    chk({tag, "_stb"},  32'(s_stb_o), 32'h0);
    chk({tag, "_we"},   32'(s_we_o), 32'h0);
    chk({tag, "_sel"},  32'(s_sel_o), 32'h0);
    chk({tag, "_adr"},  s_adr_o, 32'hFFFF_FFFF);
    chk({tag, "_sdat"}, s_dat_o, 32'h0);
    chk({tag, "_core"}, 32'(s_core_o), 32'h0);
  endtask

  // Starts at a negedge with the arbiter idle and requests pending.
  task automatic grant_check(output int gi);
    logic [3:0] r;
    r  = cyc_v & stb_v;
    gi = model_pick(r, last_m);
    last_m = gi;
    @(posedge clk_i); @(negedge clk_i);
    chk("grant_cyc",  32'(s_cyc_o), 32'h1);
    chk("grant_stb",  32'(s_stb_o), 32'h1);
    chk("grant_core", 32'(s_core_o), 32'(gi));
    chk("grant_adr",  s_adr_o, f_adr[gi]);
    chk("grant_dat",  s_dat_o, f_dat[gi]);
    chk("grant_sel",  32'(s_sel_o), 32'(f_sel[gi]));
    chk("grant_we",   32'(s_we_o), 32'(f_we[gi]));
  endtask

  task automatic run_txn(input int dly, input logic [31:0] rd, output int gi);
    logic [3:0] oh;
    int hold;
    grant_check(gi);
    oh = 4'b0001 << gi;
    repeat (dly) begin
      @(posedge clk_i); @(negedge clk_i);
      chk("busy_adr_stable", s_adr_o, f_adr[gi]);
      chk("busy_no_ack", 32'(m_ack_o), 32'h0);
    end
    s_ack_i  = 1'b1;
    s_dat_i  = rd;
    s_core_i = 6'($urandom);
    @(posedge clk_i); @(negedge clk_i);
    s_ack_i = 1'b0;
    s_dat_i = $urandom;
    chk("ack_vec",  32'(m_ack_o), 32'(oh));
    chk("ack_data", m_dat_o, rd);
    chk("ack_err",  32'(m_err_o), 32'h0);
    chk("ack_cyc",  32'(s_cyc_o), 32'h0);
    hold = $urandom_range(0, 2);
    repeat (hold) begin
      @(posedge clk_i); @(negedge clk_i);
      chk("hold_ack", 32'(m_ack_o), 32'(oh));
      chk("hold_dat", m_dat_o, rd);
    end
    cyc_v[gi] = 1'b0;
    stb_v[gi] = 1'b0;
    @(posedge clk_i); @(negedge clk_i);
    chk("release_ack", 32'(m_ack_o), 32'h0);
    chk("release_dat", m_dat_o, 32'h0);
  endtask

  initial begin
    logic [31:0] rd;
    rst_ni   = 1'b0;
    cyc_v    = '0;
    stb_v    = '0;
    f_we     = '0;
    s_ack_i  = 1'b0;
    s_dat_i  = '0;
    s_core_i = '0;
    for (int k = 0; k < 4; k++) begin
      f_sel[k] = '0; f_adr[k] = '0; f_dat[k] = '0;
    end
    repeat (2) @(negedge clk_i);
    chk_reset_outputs("reset");
    rst_ni = 1'b1;
    @(negedge clk_i);

    // All four request continuously: expect 0,1,2,3,0.
    for (int k = 0; k < 4; k++) raise(k);
    for (int i = 0; i < 5; i++) begin
      run_txn($urandom_range(0, 3), $urandom, g);
      if (i < 4) raise(g);
    end
    cyc_v = '0; stb_v = '0;
    @(posedge clk_i); @(negedge clk_i);
    chk("idle_no_cyc", 32'(s_cyc_o), 32'h0);

    // Master 1 read, slave acks 3 clocks later.
    raise(1);
    f_adr[1] = 32'hFD00_0010;
    f_we[1]  = 1'b0;
    run_txn(3, 32'h1234_5678, g);

    // Master 2 write, never acked: error TMO+1 clocks after grant.
    raise(2);
    f_we[2] = 1'b1;
    grant_check(g);
    repeat (255) @(posedge clk_i);
    @(negedge clk_i);
    chk("tmo_not_yet_err", 32'(m_err_o), 32'h0);
    chk("tmo_not_yet_cyc", 32'(s_cyc_o), 32'h1);
    @(posedge clk_i); @(negedge clk_i);
    chk("tmo_err", 32'(m_err_o), 32'h4);
    chk("tmo_cyc", 32'(s_cyc_o), 32'h0);
    chk("tmo_stb", 32'(s_stb_o), 32'h0);
    chk("tmo_ack", 32'(m_ack_o), 32'h0);
    @(posedge clk_i); @(negedge clk_i);
    chk("tmo_err_held", 32'(m_err_o), 32'h4);
    cyc_v[2] = 1'b0; stb_v[2] = 1'b0;
    @(posedge clk_i); @(negedge clk_i);
    chk("tmo_err_clear", 32'(m_err_o), 32'h0);

    // Master 0 aborts while busy; pending master 1 is granted next.
    raise(0);
    raise(1);
    grant_check(g);
    cyc_v[0] = 1'b0;
    @(posedge clk_i); @(negedge clk_i);
    chk("abort_cyc", 32'(s_cyc_o), 32'h0);
    chk("abort_ack", 32'(m_ack_o), 32'h0);
    chk("abort_err", 32'(m_err_o), 32'h0);
    stb_v[0] = 1'b0;
    run_txn($urandom_range(0, 4), $urandom, g);
    chk("abort_next_grant", 32'(g), 32'h1);

    // Ack on the same clock as watchdog expiry: ack wins.
    raise(3);
    grant_check(g);
    repeat (255) @(posedge clk_i);
    @(negedge clk_i);
    rd = $urandom;
    s_ack_i = 1'b1;
    s_dat_i = rd;
    @(posedge clk_i); @(negedge clk_i);
    s_ack_i = 1'b0;
    chk("race_ack", 32'(m_ack_o), 32'h8);
    chk("race_err", 32'(m_err_o), 32'h0);
    chk("race_dat", m_dat_o, rd);
    cyc_v[3] = 1'b0; stb_v[3] = 1'b0;
    @(posedge clk_i); @(negedge clk_i);
    chk("race_release", 32'(m_ack_o), 32'h0);
    chk("race_err_after", 32'(m_err_o), 32'h0);

    // Reset asserted mid-cycle clears everything immediately.
    raise(2);
    grant_check(g);
    rst_ni = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    last_m = 3;
    for (int k = 0; k < 4; k++) raise(k);
    @(negedge clk_i);
    rst_ni = 1'b1;
    chk("midrst_no_ack", 32'(m_ack_o), 32'h0);
    run_txn(1, $urandom, g);
    chk("midrst_first_winner", 32'(g), 32'h0);

    // Randomized traffic against the reference model.
    for (int it = 0; it < 40; it++) begin
      run_txn($urandom_range(0, 4), $urandom, g);
      for (int k = 0; k < 4; k++)
        if (!cyc_v[k] && $urandom_range(0, 1) == 1) raise(k);
      if (cyc_v == 4'b0000) raise($urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
